// File: rtl/iir_sos_sequencer.sv
// Cascade of NSEC biquad sections time-shared over one compute path.
// Define IIR_SAT_EN to saturate the final output instead of wrapping.

module iir_sos_sequencer #(
    parameter int  BW        = 32,
    parameter int  NSEC      = 4,
    parameter int  FRAC      = 20,
    parameter int  OUT_SHIFT = 0,
    localparam int AW        = $clog2(5 * NSEC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [BW-1:0] cfg_data,
    output logic          cfg_err,
    input  logic          clr_state,
    output logic          busy
);

    localparam int NCOEF = 5 * NSEC;
    localparam int SW    = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int DW    = 2 * BW;
    localparam int PW    = 3 * BW;

    localparam logic [BW-1:0] UNITY = {{(BW-1){1'b0}}, 1'b1} << FRAC;
    localparam logic [SW-1:0] LAST  = SW'(NSEC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OUT
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [BW-1:0] r_coef [NCOEF];
    logic [DW-1:0] r_z1   [NSEC];
    logic [DW-1:0] r_z2   [NSEC];
    logic [DW-1:0] r_s;
    logic [SW-1:0] r_sec;
    logic [BW-1:0] r_out;
    logic          r_cfg_err;

    logic          w_accept;
    logic          w_last;
    logic          w_cfg_ok;
    logic [AW-1:0] w_base;
    logic [BW-1:0] w_k0, w_k1, w_k2, w_k3, w_k4;
    logic [DW-1:0] w_z1, w_z2;
    logic [DW-1:0] w_w, w_r;
    logic [BW-1:0] w_res;
    logic signed [PW-1:0] w_fb, w_ff;

    function automatic logic signed [PW-1:0] sx_c(input logic [BW-1:0] v);
        return {{(PW-BW){v[BW-1]}}, v};
    endfunction

    function automatic logic signed [PW-1:0] sx_z(input logic [DW-1:0] v);
        return {{(PW-DW){v[DW-1]}}, v};
    endfunction

    function automatic logic [DW-1:0] q_trunc(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] t;
        t = v >>> FRAC;
        return t[DW-1:0];
    endfunction

    function automatic logic [BW-1:0] finish(input logic [DW-1:0] v);
        logic signed [DW-1:0] t;
        t = $signed(v) >>> OUT_SHIFT;
`ifdef IIR_SAT_EN
        if (&t[DW-1:BW-1] || ~|t[DW-1:BW-1])
            return t[BW-1:0];
        else if (t[DW-1])
            return {1'b1, {(BW-1){1'b0}}};
        else
            return {1'b0, {(BW-1){1'b1}}};
`else
        return t[BW-1:0];
`endif
    endfunction

    // Shared biquad path, operand muxing selected by the current section
    assign w_base = AW'(5 * int'(r_sec));
    assign w_k0   = r_coef[w_base];
    assign w_k1   = r_coef[w_base + AW'(1)];
    assign w_k2   = r_coef[w_base + AW'(2)];
    assign w_k3   = r_coef[w_base + AW'(3)];
    assign w_k4   = r_coef[w_base + AW'(4)];
    assign w_z1   = r_z1[r_sec];
    assign w_z2   = r_z2[r_sec];

    assign w_fb = (sx_z(r_s) <<< FRAC)
                - sx_c(w_k3) * sx_z(w_z1)
                - sx_c(w_k4) * sx_z(w_z2);
    assign w_w  = q_trunc(w_fb);
    assign w_ff = sx_c(w_k0) * sx_z(w_w)
                + sx_c(w_k1) * sx_z(w_z1)
                + sx_c(w_k2) * sx_z(w_z2);
    assign w_r   = q_trunc(w_ff);
    assign w_res = finish(w_r);

    assign w_cfg_ok = cfg_we && (r_state == S_IDLE)
                    && ({1'b0, cfg_addr} < (AW+1)'(NCOEF));

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        w_last    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_sec == LAST) begin
                    w_last = 1'b1;
                    w_next = S_OUT;
                end
            end
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s       <= '0;
            r_sec     <= '0;
            r_out     <= '0;
            r_cfg_err <= 1'b0;
            for (int i = 0; i < NSEC; i++) begin
                r_z1[i] <= '0;
                r_z2[i] <= '0;
            end
            for (int c = 0; c < NCOEF; c++)
                r_coef[c] <= (c % 5 == 0) ? UNITY : '0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
            if (w_cfg_ok)
                r_coef[cfg_addr] <= cfg_data;
            if (r_state == S_IDLE && clr_state) begin
                for (int i = 0; i < NSEC; i++) begin
                    r_z1[i] <= '0;
                    r_z2[i] <= '0;
                end
            end
            if (w_accept) begin
                r_s   <= {{BW{in_data[BW-1]}}, in_data};
                r_sec <= '0;
            end
            if (r_state == S_RUN) begin
                r_z1[r_sec] <= w_w;
                r_z2[r_sec] <= w_z1;
                r_s         <= w_r;
                r_sec       <= r_sec + SW'(1);
                if (w_last)
                    r_out <= w_res;
            end
        end
    end

    assign out_data = r_out;
    assign cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_iir_sos_sequencer.sv
// Bench for iir_sos_sequencer: directed steps plus randomized samples
// and coefficients checked against an arithmetic cascade model.

module tb_iir_sos_sequencer;

    localparam int BW        = 32;
    localparam int NSEC      = 2;
    localparam int FRAC      = 20;
    localparam int OUT_SHIFT = 0;
    localparam int NCOEF     = 5 * NSEC;
    localparam int AW        = $clog2(NCOEF);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] out_data;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [BW-1:0] cfg_data = '0;
    logic          cfg_err;
    logic          clr_state = 1'b0;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_coef [NCOEF];
    longint      m_z1   [NSEC];
    longint      m_z2   [NSEC];
    logic [31:0] exp_q  [$];

    iir_sos_sequencer #(
        .BW(BW), .NSEC(NSEC), .FRAC(FRAC), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_err(cfg_err), .clr_state(clr_state), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [95:0] w96(input longint v);
        return {{32{v[63]}}, v};
    endfunction

    function automatic logic signed [95:0] c96(input int c);
        return {{64{c[31]}}, c};
    endfunction

    task automatic model_reset;
        for (int i = 0; i < NCOEF; i++)
            m_coef[i] = (i % 5 == 0) ? (1 << FRAC) : 0;
        for (int i = 0; i < NSEC; i++) begin
            m_z1[i] = 0;
            m_z2[i] = 0;
        end
    endtask

    task automatic model_clr;
        for (int i = 0; i < NSEC; i++) begin
            m_z1[i] = 0;
            m_z2[i] = 0;
        end
    endtask

    task automatic model_push(input logic [31:0] x);
        longint s, w, r;
        logic signed [95:0] t;
        logic [31:0] y;
        s = longint'($signed(x));
        for (int i = 0; i < NSEC; i++) begin
            t = (w96(s) <<< FRAC)
              - c96(m_coef[5*i+3]) * w96(m_z1[i])
              - c96(m_coef[5*i+4]) * w96(m_z2[i]);
            t = t >>> FRAC;
            w = longint'(t[63:0]);
            t = c96(m_coef[5*i]) * w96(w)
              + c96(m_coef[5*i+1]) * w96(m_z1[i])
              + c96(m_coef[5*i+2]) * w96(m_z2[i]);
            t = t >>> FRAC;
            r = longint'(t[63:0]);
            m_z2[i] = m_z1[i];
            m_z1[i] = w;
            s = r;
        end
        s = s >>> OUT_SHIFT;
`ifdef IIR_SAT_EN
        if (s > 64'sd2147483647)
            y = 32'h7fffffff;
        else if (s < -64'sd2147483648)
            y = 32'h80000000;
        else
            y = s[31:0];
`else
        y = s[31:0];
`endif
        exp_q.push_back(y);
    endtask

    task automatic accept(input logic [31:0] x);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = x;
        while (!in_ready && g < 200) begin
            tick;
            g++;
        end
        check("in_ready_idle", in_ready, 1);
        model_push(x);
        tick;
        in_valid = 1'b0;
        check("busy_run", busy, 1);
        check("in_ready_run", in_ready, 0);
    endtask

    task automatic recv(input string tag, input int hold, input bit lat,
                        output logic [31:0] got);
        int c;
        logic [31:0] d0, e;
        c = 0;
        while (!out_valid && c < 200) begin
            tick;
            c++;
        end
        if (lat)
            check({tag, "_latency"}, c, NSEC);
        check({tag, "_valid"}, out_valid, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdeadbeef;
        d0 = out_data;
        for (int h = 0; h < hold; h++) begin
            tick;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_data"}, out_data, d0);
            check({tag, "_hold_inrdy"}, in_ready, 0);
        end
        check(tag, out_data, e);
        got = out_data;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_inrdy"}, in_ready, 1);
    endtask

    task automatic cfg(input int a, input logic [31:0] d, input bit err);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = d;
        tick;
        cfg_we = 1'b0;
        check("cfg_err", cfg_err, err);
        if (!err)
            m_coef[a] = d;
        tick;
        check("cfg_err_pulse", cfg_err, 0);
    endtask

    task automatic clr;
        clr_state = 1'b1;
        tick;
        clr_state = 1'b0;
        model_clr;
    endtask

    initial begin
        logic [31:0] got;
        int a;
        int d;
        model_reset;
        repeat (3) tick;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        tick;

        accept(32'd1000);
        recv("pass1000", 0, 1, got);
        check("pass1000_const", got, 1000);

        accept(32'd50);
        cfg_we   = 1'b1;
        cfg_addr = '0;
        cfg_data = '0;
        tick;
        cfg_we = 1'b0;
        check("cfg_err_run", cfg_err, 1);
        tick;
        check("cfg_err_run_pulse", cfg_err, 0);
        recv("run_write_blocked", 0, 0, got);
        cfg(10, 32'd0, 1);
        accept(32'd77);
        recv("pass77", 0, 1, got);
        check("pass77_const", got, 77);

        cfg(3, 32'hfff80000, 0);
        clr;
        accept(32'd1024);
        recv("imp0", 0, 1, got);
        check("imp0_const", got, 1024);
        for (int i = 1; i < 5; i++) begin
            accept(32'd0);
            recv("imp", 0, 1, got);
            check("imp_const", got, 32'd1024 >> i);
        end

        clr;
        accept(32'd0);
        recv("after_clr", 0, 1, got);
        check("after_clr_const", got, 0);

        accept(32'd300);
        in_valid = 1'b1;
        in_data  = 32'd400;
        recv("stall", 5, 1, got);
        accept(32'd400);
        recv("after_stall", 0, 1, got);

        cfg(5, 32'h00200000, 0);
        accept(32'd123);
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_out_data", out_data, 0);
        exp_q.delete();
        model_reset;
        accept(32'd5);
        recv("midrst_pass5", 0, 1, got);
        check("midrst_pass5_const", got, 5);

        cfg(0, 32'h40000000, 0);
        clr;
        accept(32'h02000000);
        recv("sat", 0, 1, got);
`ifdef IIR_SAT_EN
        check("sat_const", got, 32'h7fffffff);
`else
        check("wrap_const", got, 32'h00000000);
`endif

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = int'($urandom_range(0, 11));
                d = int'($urandom_range(0, 1 << 22)) - (1 << 21);
                cfg(a, d, a >= NCOEF);
            end
            if ($urandom_range(0, 7) == 0)
                clr;
            d = int'($urandom_range(0, 65535)) - 32768;
            accept(d);
            recv("rand", int'($urandom_range(0, 3)), 1, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
